// File: rtl/chronos_pkg.sv
// Shared definitions for the chronos fetch-path predictors: default
// address width and the 2-bit direction counter encodings.
package chronos_pkg;

    localparam int XLEN_DEF = 32;

    // Direction counter encodings: strongly/weakly not-taken, weakly/strongly taken
    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    // Counter value after reset, and for a freshly allocated entry
    localparam logic [1:0] CTR_RESET = CTR_WNT;
    localparam logic [1:0] CTR_ALLOC = CTR_WT;

    // The MSB of the counter is the taken prediction
    function automatic logic ctr_predicts_taken(input logic [1:0] ctr);
        return ctr[1];
    endfunction

endpackage

// File: rtl/sat_counter2.sv
// 2-bit saturating counter next-state: moves towards taken or not-taken
// by one step and holds at the ends (00 and 11).
module sat_counter2
    import chronos_pkg::*;
(
    input  logic [1:0] ctr_in,
    input  logic       taken,
    output logic [1:0] ctr_out
);

    // Step the counter one position in the direction of the outcome, saturating
    always_comb begin
        ctr_out = ctr_in;
        if (taken) begin
            if (ctr_in != CTR_ST) begin
                ctr_out = ctr_in + 2'd1;
            end
        end else begin
            if (ctr_in != CTR_SNT) begin
                ctr_out = ctr_in - 2'd1;
            end
        end
    end

endmodule

// File: rtl/btb_predictor.sv
// Direct-mapped branch target buffer with 2-bit direction counters.
// Lookup is combinational from the table flops (zero latency); training
// happens at the clock edge from resolved EX outcomes. inval_all flash
// clears every valid bit and overrides a same-cycle update.
// Optional statistics counters are built when BTB_STATS_EN is defined;
// otherwise the stat_* ports are tied to zero.
module btb_predictor
    import chronos_pkg::*;
#(
    parameter int XLEN    = XLEN_DEF,
    parameter int ENTRIES = 64,
    parameter int TAG_W   = XLEN - $clog2(ENTRIES) - 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] lookup_pc,
    output logic            pred_hit,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            upd_en,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target,
    input  logic            upd_mispredict,
    input  logic            inval_all,
    output logic [31:0]     stat_lookups,
    output logic [31:0]     stat_mispredicts
);

    localparam int IDX_W = $clog2(ENTRIES);

    // Valid bits live in one vector so a flash clear is a single assignment
    logic [ENTRIES-1:0] valid_reg;
    logic [TAG_W-1:0]   tag_arr    [ENTRIES];
    logic [XLEN-1:0]    target_arr [ENTRIES];
    logic [1:0]         ctr_arr    [ENTRIES];

    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_hit;
    logic             do_write;
    logic [1:0]       ctr_step;
    logic [1:0]       ctr_next;

    assign lk_idx  = lookup_pc[IDX_W+1:2];
    assign lk_tag  = lookup_pc[IDX_W+2 +: TAG_W];
    assign upd_idx = upd_pc[IDX_W+1:2];
    assign upd_tag = upd_pc[IDX_W+2 +: TAG_W];

    // Fetch-side lookup straight from the table; a miss or not-taken falls through to pc+4
    always_comb begin
        pred_hit    = valid_reg[lk_idx] && (tag_arr[lk_idx] == lk_tag);
        pred_taken  = pred_hit && ctr_predicts_taken(ctr_arr[lk_idx]);
        pred_target = pred_taken ? target_arr[lk_idx] : lookup_pc + XLEN'(4);
    end

    sat_counter2 u_sat_counter2 (
        .ctr_in  (ctr_arr[upd_idx]),
        .taken   (upd_taken),
        .ctr_out (ctr_step)
    );

    // Write decision; upd_en gates everything so X on idle upd_* cannot reach state.
    // A miss that was not taken leaves the table untouched.
    always_comb begin
        upd_hit  = valid_reg[upd_idx] && (tag_arr[upd_idx] == upd_tag);
        do_write = upd_en && !inval_all && (upd_hit || upd_taken);
        ctr_next = upd_hit ? ctr_step : CTR_ALLOC;
    end

    // Valid vector: flash clear wins, otherwise any write marks its entry valid
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_reg <= '0;
        end else if (inval_all) begin
            valid_reg <= '0;
        end else if (do_write) begin
            valid_reg[upd_idx] <= 1'b1;
        end
    end

    // Per-entry tag/target/counter storage, each entry owning its flops
    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
        logic             sel;
        logic [TAG_W-1:0] tag_reg;
        logic [XLEN-1:0]  target_reg;
        logic [1:0]       ctr_reg;

        assign sel = do_write && (upd_idx == IDX_W'(gi));

        // Rewriting the tag on a hit is harmless (same value) and covers allocation;
        // the target only changes on a taken outcome
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                tag_reg    <= '0;
                target_reg <= '0;
                ctr_reg    <= CTR_RESET;
            end else if (sel) begin
                tag_reg <= upd_tag;
                ctr_reg <= ctr_next;
                if (upd_taken) begin
                    target_reg <= upd_target;
                end
            end
        end

        assign tag_arr[gi]    = tag_reg;
        assign target_arr[gi] = target_reg;
        assign ctr_arr[gi]    = ctr_reg;
    end

`ifdef BTB_STATS_EN
    logic [31:0] lookups_reg;
    logic [31:0] mispredicts_reg;
    logic        unused_pc_bits;

    // Free-running fetch count and EX-reported mispredict count, both wrapping
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            lookups_reg     <= '0;
            mispredicts_reg <= '0;
        end else begin
            lookups_reg <= lookups_reg + 32'd1;
            if (upd_en && upd_mispredict) begin
                mispredicts_reg <= mispredicts_reg + 32'd1;
            end
        end
    end

    assign stat_lookups     = lookups_reg;
    assign stat_mispredicts = mispredicts_reg;
    assign unused_pc_bits   = ^{lookup_pc[1:0], upd_pc[1:0]};
`else
    logic unused_pc_bits;

    assign stat_lookups     = '0;
    assign stat_mispredicts = '0;
    assign unused_pc_bits   = ^{lookup_pc[1:0], upd_pc[1:0], upd_mispredict};
`endif

endmodule

// File: tb/tb_btb_predictor.sv
// Directed bench for btb_predictor (XLEN=32, ENTRIES=64). Inputs change on
// the falling edge; outputs are compared 1ns later, away from the rising edge.
module tb_btb_predictor;

    logic        clk;
    logic        rst;
    logic [31:0] lookup_pc;
    logic        pred_hit;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        upd_en;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        upd_mispredict;
    logic        inval_all;
    logic [31:0] stat_lookups;
    logic [31:0] stat_mispredicts;

    int n_vec  = 0;
    int n_err  = 0;
    int exp_misp = 0;
    logic [31:0] snap;

    btb_predictor #(.XLEN(32), .ENTRIES(64)) dut (
        .clk              (clk),
        .rst              (rst),
        .lookup_pc        (lookup_pc),
        .pred_hit         (pred_hit),
        .pred_taken       (pred_taken),
        .pred_target      (pred_target),
        .upd_en           (upd_en),
        .upd_pc           (upd_pc),
        .upd_taken        (upd_taken),
        .upd_target       (upd_target),
        .upd_mispredict   (upd_mispredict),
        .inval_all        (inval_all),
        .stat_lookups     (stat_lookups),
        .stat_mispredicts (stat_mispredicts)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
        $display("vec %0d %s observed=%h expected=%h", n_vec, tag, obs, exp);
    endtask

    // Check hit/taken/target for a given fetch PC
    task automatic look(input string tag, input logic [31:0] pc,
                        input logic hit, input logic tk, input logic [31:0] tgt);
        lookup_pc = pc;
        #1;
        check({tag, ".hit"},    32'(pred_hit),   32'(hit));
        check({tag, ".taken"},  32'(pred_taken), 32'(tk));
        check({tag, ".target"}, pred_target,     tgt);
    endtask

    // One training strobe; upd_* go to X afterwards to show idle inputs are ignored
    task automatic train(input logic [31:0] pc, input logic tk, input logic [31:0] tgt,
                         input logic misp);
        upd_en         = 1'b1;
        upd_pc         = pc;
        upd_taken      = tk;
        upd_target     = tgt;
        upd_mispredict = misp;
`ifdef BTB_STATS_EN
        if (misp) exp_misp++;
`endif
        @(negedge clk);
        upd_en         = 1'b0;
        upd_pc         = 'x;
        upd_taken      = 1'bx;
        upd_target     = 'x;
        upd_mispredict = 1'bx;
    endtask

    initial begin
        rst = 1'b0;
        lookup_pc = 32'h100;
        upd_en = 1'b0; upd_pc = '0; upd_taken = 1'b0; upd_target = '0;
        upd_mispredict = 1'b0; inval_all = 1'b0;

        // Reset state
        #12;
        look("reset", 32'h100, 1'b0, 1'b0, 32'h104);
        check("reset.stat_lookups", stat_lookups, 32'h0);
        check("reset.stat_mispredicts", stat_mispredicts, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // Allocate on taken miss
        train(32'h100, 1'b1, 32'h200, 1'b1);
        look("alloc", 32'h100, 1'b1, 1'b1, 32'h200);

        // Counter walk 10 -> 01 -> 00 -> 00 -> 01 -> 10 -> 11
        train(32'h100, 1'b0, 32'h0, 1'b1);
        look("nt1", 32'h100, 1'b1, 1'b0, 32'h104);
        train(32'h100, 1'b0, 32'h0, 1'b0);
        look("nt2", 32'h100, 1'b1, 1'b0, 32'h104);
        train(32'h100, 1'b0, 32'h0, 1'b0);
        look("nt3_sat", 32'h100, 1'b1, 1'b0, 32'h104);
        train(32'h100, 1'b1, 32'h200, 1'b0);
        look("t1", 32'h100, 1'b1, 1'b0, 32'h104);
        train(32'h100, 1'b1, 32'h200, 1'b0);
        look("t2", 32'h100, 1'b1, 1'b1, 32'h200);
        train(32'h100, 1'b1, 32'h200, 1'b0);
        train(32'h100, 1'b1, 32'h250, 1'b0);
        look("t_sat_newtgt", 32'h100, 1'b1, 1'b1, 32'h250);
        // From 11 one not-taken gives 10: still taken, target kept
        train(32'h100, 1'b0, 32'h999, 1'b0);
        look("st_nt_keep", 32'h100, 1'b1, 1'b1, 32'h250);

        // Aliasing on the same index with a different tag
        look("alias_miss", 32'h200, 1'b0, 1'b0, 32'h204);
        train(32'h200, 1'b1, 32'h300, 1'b0);
        look("alias_old", 32'h100, 1'b0, 1'b0, 32'h104);
        look("alias_new", 32'h200, 1'b1, 1'b1, 32'h300);
        look("low_bits_ignored", 32'h203, 1'b1, 1'b1, 32'h300);

        // Not-taken miss does not allocate
        train(32'h104, 1'b0, 32'h777, 1'b0);
        look("nt_miss", 32'h104, 1'b0, 1'b0, 32'h108);

        // Same-cycle lookup and update: pre-update view now, new state next cycle
        train(32'h100, 1'b1, 32'h200, 1'b0);
        lookup_pc = 32'h100;
        upd_en = 1'b1; upd_pc = 32'h100; upd_taken = 1'b0;
        upd_target = 32'h0; upd_mispredict = 1'b0;
        #1;
        check("same_cycle.before", 32'(pred_taken), 32'd1);
        @(negedge clk);
        upd_en = 1'b0;
        look("same_cycle.after", 32'h100, 1'b1, 1'b0, 32'h104);

        // Flash invalidate beats a simultaneous allocating update
        inval_all = 1'b1;
        upd_en = 1'b1; upd_pc = 32'h140; upd_taken = 1'b1;
        upd_target = 32'h500; upd_mispredict = 1'b0;
        @(negedge clk);
        inval_all = 1'b0; upd_en = 1'b0;
        look("inval_100", 32'h100, 1'b0, 1'b0, 32'h104);
        look("inval_200", 32'h200, 1'b0, 1'b0, 32'h204);
        look("inval_140", 32'h140, 1'b0, 1'b0, 32'h144);

        // pc+4 wraps at the top of the address space
        look("wrap", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0000_0000);

        // Stats: mispredict strobes so far plus lookups over a 5-cycle window
        check("stat_misp_running", stat_mispredicts, 32'(exp_misp));
        snap = stat_lookups;
        repeat (5) @(negedge clk);
        #1;
`ifdef BTB_STATS_EN
        check("stat_lookups_delta", stat_lookups - snap, 32'd5);
`else
        check("stat_lookups_tied", stat_lookups, 32'h0);
`endif

        // Reset mid-stream wipes the table and counters immediately
        train(32'h180, 1'b1, 32'h600, 1'b0);
        look("pre_reset", 32'h180, 1'b1, 1'b1, 32'h600);
        rst = 1'b0;
        look("mid_reset", 32'h180, 1'b0, 1'b0, 32'h184);
        check("mid_reset.stat_mispredicts", stat_mispredicts, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        exp_misp = 0;

        // Three mispredict strobes after reset
        train(32'h180, 1'b0, 32'h0, 1'b1);
        train(32'h184, 1'b0, 32'h0, 1'b1);
        train(32'h188, 1'b0, 32'h0, 1'b1);
        #1;
        check("stat_misp_three", stat_mispredicts, 32'(exp_misp));
        look("post_reset_nt", 32'h180, 1'b0, 1'b0, 32'h184);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
